// File: rtl/alk_shift_seq.sv
// alk_shift_seq: multi-step shift sequencer driving an external ALU shift path and
// a 32-bit Q register.
//
// A start in IDLE latches direction, step count (0 means 32) and shift-in source, then
// performs one shift step per SHIFT cycle. After the last step a one-cycle DONE
// follows and the block returns to IDLE. An abort during SHIFT still completes that
// cycle's step, then returns to IDLE with no done pulse.
//
// Optional feature: define ALK_SHIFT_SEQ_STICKY_EN to build the sticky register, which
// ORs every bit shifted out of the ALU on a right shift. It is cleared when a start is
// accepted. Without the macro, sticky_h is tied low.
//
// Ports:
//   clk              clock, rising edge
//   reset_h          synchronous active-high reset
//   start_h          begin a sequence (sampled in IDLE only)
//   abort_h          terminate a sequence in SHIFT
//   dir_shr_h        direction latched at start (1 = right, 0 = left)
//   count_h          step count latched at start (0 encodes 32)
//   sin_sel_h        shift-in source: 0 zero, 1 one, 2 sign_in_h, 3 Q link, 4-7 zero
//   sign_in_h        live sign bit
//   q_load_h/q_din_h parallel load of Q (IDLE/DONE only)
//   alu_sout_shl_h   bit shifted out of the ALU on a left shift
//   alu_sout_shr_h   bit shifted out of the ALU on a right shift
//   alpctl_shl_op_h  left-shift step in progress
//   alpctl_shr_op_h  right-shift step in progress
//   alu_sin_h        bit shifted into the ALU
//   busy_h           high in SHIFT
//   done_h           one-cycle pulse in DONE
//   q_dout_h         Q register
//   sticky_h         sticky OR of right-shift outputs (zero when the feature is off)
module alk_shift_seq (
  input  logic        clk,
  input  logic        reset_h,
  input  logic        start_h,
  input  logic        abort_h,
  input  logic        dir_shr_h,
  input  logic [4:0]  count_h,
  input  logic [2:0]  sin_sel_h,
  input  logic        sign_in_h,
  input  logic        q_load_h,
  input  logic [31:0] q_din_h,
  input  logic        alu_sout_shl_h,
  input  logic        alu_sout_shr_h,
  output logic        alpctl_shl_op_h,
  output logic        alpctl_shr_op_h,
  output logic        alu_sin_h,
  output logic        busy_h,
  output logic        done_h,
  output logic [31:0] q_dout_h,
  output logic        sticky_h
);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e      state_q;
  logic [5:0]  step_q;
  logic        dir_q;
  logic [2:0]  sel_q;
  logic [31:0] q_q;
  logic        busy_q;
  logic        done_q;
`ifdef ALK_SHIFT_SEQ_STICKY_EN
  logic        sticky_q;
`endif

  always_ff @(posedge clk) begin
    if (reset_h) begin
      state_q  <= StIdle;
      step_q   <= 6'd0;
      dir_q    <= 1'b0;
      sel_q    <= 3'd0;
      q_q      <= 32'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef ALK_SHIFT_SEQ_STICKY_EN
      sticky_q <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          // A load in the same cycle as a start feeds the first shift step.
          if (q_load_h) q_q <= q_din_h;
          if (start_h) begin
            dir_q    <= dir_shr_h;
            sel_q    <= sin_sel_h;
            step_q   <= (count_h == 5'd0) ? 6'd32 : {1'b0, count_h};
            state_q  <= StShift;
            busy_q   <= 1'b1;
`ifdef ALK_SHIFT_SEQ_STICKY_EN
            sticky_q <= 1'b0;
`endif
          end
        end
        StShift: begin
          q_q    <= dir_q ? {alu_sout_shr_h, q_q[31:1]} : {q_q[30:0], alu_sout_shl_h};
          step_q <= step_q - 6'd1;
`ifdef ALK_SHIFT_SEQ_STICKY_EN
          if (dir_q) sticky_q <= sticky_q | alu_sout_shr_h;
`endif
          // Abort wins over a final step: the step happens, the done pulse does not.
          if (abort_h) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end else if (step_q == 6'd1) begin
            state_q <= StDone;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        StDone: begin
          if (q_load_h) q_q <= q_din_h;
          state_q <= StIdle;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    alu_sin_h = 1'b0;
    if (busy_q) begin
      case (sel_q)
        3'd1:    alu_sin_h = 1'b1;
        3'd2:    alu_sin_h = sign_in_h;
        // Q link closes the 64-bit ALU:Q rotate.
        3'd3:    alu_sin_h = dir_q ? q_q[0] : q_q[31];
        default: alu_sin_h = 1'b0;
      endcase
    end
  end

  assign alpctl_shr_op_h = busy_q & dir_q;
  assign alpctl_shl_op_h = busy_q & ~dir_q;
  assign busy_h          = busy_q;
  assign done_h          = done_q;
  assign q_dout_h        = q_q;
`ifdef ALK_SHIFT_SEQ_STICKY_EN
  assign sticky_h        = sticky_q;
`else
  assign sticky_h        = 1'b0;
`endif

endmodule
